// File: rtl/pio_cmd_queue.sv
// pio_cmd_queue: captures HPS instruction words on an enqueue toggle into a
// circular FIFO and issues them one at a time to the coprocessor over a
// valid/ready handshake, reporting empty/full/done/error via the status PIO.
module pio_cmd_queue #(
    parameter int INSTR_W = 29,
    parameter int DEPTH   = 8,
    parameter int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] pio_instruction,
    input  logic [1:0]         pio_control,
    output logic [3:0]         pio_status,
    output logic [INSTR_W-1:0] cmd_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    input  logic               cop_done,
    input  logic               cop_error,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               tog_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] cmd_data_q, cmd_data_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               empty_q, full_q;

    logic flush, enq_req, fifo_full, fifo_empty;
    logic push, overflow, pop, cop_err_hit, cop_done_hit;

    // Request decode; flush masks every state-changing event for the cycle
    always_comb begin
        flush        = pio_control[1];
        enq_req      = pio_control[0] ^ tog_q;
        fifo_full    = (level_q == LVL_W'(DEPTH));
        fifo_empty   = (level_q == '0);
        push         = enq_req && !flush && !fifo_full;
        overflow     = enq_req && !flush && fifo_full;
        pop          = (state_q == ST_IDLE) && !fifo_empty && !flush;
        cop_err_hit  = (state_q == ST_BUSY) && cop_error && !flush;
        cop_done_hit = (state_q == ST_BUSY) && cop_done && !cop_error && !flush;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
                ST_ISSUE: if (cmd_valid_q && cmd_ready) state_d = ST_BUSY;
                ST_BUSY:  if (cop_error || cop_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: valid tracks the ISSUE state, head word latched on pop
    always_comb begin
        cmd_valid_d = (state_d == ST_ISSUE);
        cmd_data_d  = pop ? mem_q[rd_ptr_q] : cmd_data_q;
    end

    // Pointer, level and sticky-flag next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        done_d   = done_q;
        error_d  = error_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            done_d   = 1'b0;
            error_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
            // a completion in the same cycle as a push leaves done set
            if (cop_done_hit) begin
                done_d = 1'b1;
            end else if (push) begin
                done_d = 1'b0;
            end
            if (overflow || cop_err_hit) begin
                error_d = 1'b1;
            end
        end
    end

    // Control and status registers; toggle tracking continues through reset and flush
    always_ff @(posedge clk) begin
        tog_q <= pio_control[0];
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            empty_q     <= (level_d == '0);
            full_q      <= (level_d == LVL_W'(DEPTH));
        end
    end

    // FIFO storage, written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= pio_instruction;
        end
    end

    assign pio_status = {error_q, done_q, full_q, empty_q};
    assign cmd_data   = cmd_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pio_cmd_queue.sv
// Randomised bench for pio_cmd_queue with a queue-based reference model,
// a per-cycle compare process and a few directed literal checks.
module tb_pio_cmd_queue;
    localparam int W  = 29;
    localparam int D  = 8;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  pio_instruction;
    logic [1:0]    pio_control;
    logic [3:0]    pio_status;
    logic [W-1:0]  cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cop_done;
    logic          cop_error;
    logic [LW-1:0] level;

    int vectors     = 0;
    int miscompares = 0;

    pio_cmd_queue #(.INSTR_W(W), .DEPTH(D)) dut (
        .clk             (clk),
        .reset           (reset),
        .pio_instruction (pio_instruction),
        .pio_control     (pio_control),
        .pio_status      (pio_status),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cop_done        (cop_done),
        .cop_error       (cop_error),
        .level           (level)
    );

    always #5 clk = ~clk;

    // Reference model: pending words in a queue, the outstanding command
    // described by a phase (0 none, 1 offered, 2 executing), sticky flags.
    logic [W-1:0] mq[$];
    int           phase    = 0;
    logic [W-1:0] m_cur    = '0;
    bit           m_done   = 0;
    bit           m_err    = 0;
    logic         m_tog    = 1'b0;
    bit           model_on = 0;

    always @(posedge clk) begin : model
        bit req, was_full, push_ok, done_set;
        if (reset) begin
            mq.delete();
            phase    = 0;
            m_cur    = '0;
            m_done   = 0;
            m_err    = 0;
            m_tog    = pio_control[0];
            model_on = 1;
        end else begin
            req   = (pio_control[0] != m_tog);
            m_tog = pio_control[0];
            if (pio_control[1]) begin
                mq.delete();
                phase  = 0;
                m_done = 0;
                m_err  = 0;
            end else begin
                was_full = (mq.size() == D);
                push_ok  = 0;
                done_set = 0;
                case (phase)
                    0: if (mq.size() > 0) begin m_cur = mq.pop_front(); phase = 1; end
                    1: if (cmd_ready) phase = 2;
                    2: if (cop_error) begin m_err = 1; phase = 0; end
                       else if (cop_done) begin done_set = 1; phase = 0; end
                    default: phase = 0;
                endcase
                if (req) begin
                    if (was_full) m_err = 1;
                    else begin mq.push_back(pio_instruction); push_ok = 1; end
                end
                if (done_set) m_done = 1;
                else if (push_ok) m_done = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_on) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(phase == 1));
            chk("level", 32'(level), 32'(mq.size()));
            chk("pio_status", 32'(pio_status),
                32'({m_err, m_done, (mq.size() == D), (mq.size() == 0)}));
            if (phase == 1) chk("cmd_data", 32'(cmd_data), 32'(m_cur));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic toggle(input logic [W-1:0] w);
        pio_instruction = w;
        pio_control[0]  = ~pio_control[0];
    endtask

    initial begin
        reset = 1'b1; pio_control = 2'b01; pio_instruction = '0;
        cmd_ready = 1'b0; cop_done = 1'b0; cop_error = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step(); step();
        chk("lit_reset_status", 32'(pio_status), 32'h1);
        chk("lit_reset_level", 32'(level), 32'h0);
        chk("lit_reset_valid", 32'(cmd_valid), 32'h0);

        // single command: two-cycle latency, then done
        toggle(29'h0ABCDEF); cmd_ready = 1'b1;
        step();
        chk("lit_push_level", 32'(level), 32'h1);
        step();
        chk("lit_issue_valid", 32'(cmd_valid), 32'h1);
        chk("lit_issue_data", 32'(cmd_data), 32'h0ABCDEF);
        step();
        chk("lit_hs_valid", 32'(cmd_valid), 32'h0);
        repeat (4) step();
        cop_done = 1'b1;
        step();
        cop_done = 1'b0;
        chk("lit_done_status", 32'(pio_status), 32'h5);

        // overflow with the consumer stalled
        cmd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            toggle(W'(32'h100 + i));
            step();
        end
        chk("lit_ovf_level", 32'(level), 32'h8);
        chk("lit_ovf_status", 32'(pio_status), 32'hA);
        chk("lit_ovf_data", 32'(cmd_data), 32'h100);

        // drain, order checked by the model
        cmd_ready = 1'b1; cop_done = 1'b1;
        repeat (40) step();
        cop_done = 1'b0;
        chk("lit_drain_status", 32'(pio_status), 32'hD);
        pio_control[1] = 1'b1;
        step();
        pio_control[1] = 1'b0;
        chk("lit_flush_status", 32'(pio_status), 32'h1);

        // done and error together: error wins
        toggle(29'h1234567);
        step(); step(); step();
        cop_done = 1'b1; cop_error = 1'b1;
        step();
        cop_done = 1'b0; cop_error = 1'b0;
        chk("lit_both_status", 32'(pio_status), 32'h9);
        toggle(29'h0000777);
        step(); step();
        chk("lit_next_valid", 32'(cmd_valid), 32'h1);
        chk("lit_next_data", 32'(cmd_data), 32'h777);
        pio_control[1] = 1'b1;
        step();
        pio_control[1] = 1'b0; cmd_ready = 1'b0;

        // push on the same edge as a pop at level 3
        toggle(29'hA1); step();
        toggle(29'hB2); step();
        toggle(29'hC3); step();
        toggle(29'hD4); step();
        cmd_ready = 1'b1; step();
        cmd_ready = 1'b0; cop_done = 1'b1; step();
        cop_done = 1'b0; toggle(29'hE5); step();
        chk("lit_pp_level", 32'(level), 32'h3);
        chk("lit_pp_data", 32'(cmd_data), 32'hB2);
        cmd_ready = 1'b1; toggle(29'hF6); step();
        cmd_ready = 1'b0;
        pio_control[1] = 1'b1; step();
        pio_control[1] = 1'b0;
        chk("lit_busyflush_level", 32'(level), 32'h0);
        chk("lit_busyflush_status", 32'(pio_status), 32'h1);
        cop_done = 1'b1; step();
        cop_done = 1'b0;
        chk("lit_late_done_status", 32'(pio_status), 32'h1);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            reset          = ($urandom_range(0, 199) == 0);
            pio_control[1] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 4) toggle(W'($urandom));
            cmd_ready = ($urandom_range(0, 9) < 6);
            cop_done  = ($urandom_range(0, 3) == 0);
            cop_error = ($urandom_range(0, 19) == 0);
        end
        reset = 1'b0; pio_control[1] = 1'b0;
        cop_done = 1'b0; cop_error = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
